axil_mem_responder: RTL and testbench
=====================================

Name: axil_mem_responder

Overview:
Synthesizable AXI-lite slave (responder) backed by a word-addressed register-array memory. It is the far-end target for AXI-lite master traffic, such as switchboard-driven sim masters, and is used for loopback and regression benches. Write and read paths are independent. Each path has one outstanding transaction.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
DEPTH, 256, memory depth in words (power of 2, DEPTH*STRB_WIDTH <= 2**ADDR_WIDTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
s_axil_awaddr  input  ADDR_WIDTH  write byte address
s_axil_awprot  input  3  ignored
s_axil_awvalid  input  1  AW valid
s_axil_awready  output  1  AW ready
s_axil_wdata  input  DATA_WIDTH  write data
s_axil_wstrb  input  STRB_WIDTH  byte enables
s_axil_wvalid  input  1  W valid
s_axil_wready  output  1  W ready
s_axil_bresp  output  2  write response
s_axil_bvalid  output  1  B valid
s_axil_bready  input  1  B ready
s_axil_araddr  input  ADDR_WIDTH  read byte address
s_axil_arprot  input  3  ignored
s_axil_arvalid  input  1  AR valid
s_axil_arready  output  1  AR ready
s_axil_rdata  output  DATA_WIDTH  read data
s_axil_rresp  output  2  read response
s_axil_rvalid  output  1  R valid
s_axil_rready  input  1  R ready

Behaviour:
- Reset (rst=1 at an edge): bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0. Held AW/W flags cleared; both FSMs go to idle. awready/wready/arready are forced 0 while rst=1. Memory contents are untouched. Reset mid-transaction drops it with no response.
- Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. Low address bits are ignored.
- Write FSM, W_COLLECT:
  - awready=!aw_held and wready=!w_held, so AW and W are accepted in either order or in the same cycle.
  - Each handshake latches its payload and sets its held flag.
  - Once both are held (including the cycle the second arrives), the next edge writes memory using per-byte wstrb, sets bvalid=1 and bresp=OKAY, and moves to W_RESP.
  - Minimum latency: AW+W handshake in cycle N, bvalid in N+1.
- Write FSM, W_RESP:
  - awready=wready=0. bvalid and bresp are held until bready=1.
  - On the B handshake edge: flags clear, return to W_COLLECT, readys high the next cycle.
  - wstrb=0 completes with OKAY and leaves memory unchanged.
- Read FSM, R_IDLE: arready=1. An AR handshake registers rdata=mem[idx], sets rvalid=1 and rresp=OKAY, and moves to R_RESP. rvalid rises in N+1.
- Read FSM, R_RESP: arready=0. rdata and rresp stay stable until rready=1. On the R handshake, return to R_IDLE.
- Same-edge read and write to the same word: the read returns the old data (read-before-write).
- Valid inputs deasserting before the handshake are tolerated (non-compliant masters); no state change results.
- Out-of-range addresses (idx >= DEPTH) wrap modulo DEPTH and return OKAY, unless the optional feature is enabled.

Optional Feature:
AXIL_MEM_DECERR_EN:
- Defined: any address with idx >= DEPTH is rejected. Writes are dropped with bresp=2'b11 (DECERR). Reads return rdata=0 with rresp=2'b11. Timing is unchanged.
- Undefined: the address wraps modulo DEPTH and the response is always OKAY.

Test Plan:
- AW and W same cycle: addr 0x0010, data 0xDEADBEEF, strb 0xF -> bvalid at N+1, bresp=0; a read of 0x0010 returns 0xDEADBEEF, rresp=0.
- W two cycles before AW: addr 0x0004, data 0x11223344 -> wready low after capture, bvalid one cycle after the AW handshake.
- Partial strobe over 0xFFFFFFFF: data 0x000000AB, strb 0x1 -> read returns 0xFFFFFFAB.
- Backpressure: bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0, no second write accepted. Same check for R with rready=0: rdata stable.
- Same-edge read and write of word 3 (old 0x1, new 0x2) -> read returns 0x1; a subsequent read returns 0x2.
- Reset while bvalid=1 -> bvalid=0 next cycle, readys 0 during rst, no B beat. With AXIL_MEM_DECERR_EN and DEPTH=256, read of 0x0400 -> rresp=2'b11, rdata=0.

Source files
------------

// File: rtl/axil_mem_responder_if.sv
// AXI-lite bus bundle between a master and the axil_mem_responder memory target.
interface axil_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_mem_responder.sv
// AXI-lite responder backed by a word-addressed memory; independent write/read paths.
// Define AXIL_MEM_DECERR_EN to reject addresses beyond DEPTH with DECERR instead of wrapping.
module axil_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  axil_mem_responder_if.slave   s_axil
);
  localparam int IDX_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  w_state_t              w_state_q, w_state_d;
  r_state_t              r_state_q, r_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  aw_ok_q, aw_ok_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, aw_ok, ar_ok;
  logic [IDX_W-1:0]      wr_idx, ar_idx;
  logic                  wr_ok, mem_we;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;

`ifdef AXIL_MEM_DECERR_EN
  assign aw_ok = {1'b0, s_axil.awaddr >> IDX_LSB} < (ADDR_WIDTH+1)'(DEPTH);
  assign ar_ok = {1'b0, s_axil.araddr >> IDX_LSB} < (ADDR_WIDTH+1)'(DEPTH);
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr, s_axil.araddr};

  // Readys come straight from registered state, gated low while reset is held.
  assign s_axil.awready = !rst && (w_state_q == W_COLLECT) && !aw_held_q;
  assign s_axil.wready  = !rst && (w_state_q == W_COLLECT) && !w_held_q;
  assign s_axil.arready = !rst && (r_state_q == R_IDLE);
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

  assign aw_hs  = s_axil.awvalid && s_axil.awready;
  assign w_hs   = s_axil.wvalid && s_axil.wready;
  assign ar_hs  = s_axil.arvalid && s_axil.arready;
  assign ar_idx = s_axil.araddr[IDX_LSB +: IDX_W];

  // Merge a payload arriving this cycle with whatever half is already held.
  assign wr_idx  = aw_hs ? s_axil.awaddr[IDX_LSB +: IDX_W] : aw_idx_q;
  assign wr_ok   = aw_hs ? aw_ok : aw_ok_q;
  assign wr_data = w_hs ? s_axil.wdata : wdata_q;
  assign wr_strb = w_hs ? s_axil.wstrb : wstrb_q;
  assign mem_we  = !rst && (w_state_q == W_COLLECT) && (aw_held_q || aw_hs)
                   && (w_held_q || w_hs) && wr_ok;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axil.awaddr[IDX_LSB +: IDX_W];
          aw_ok_d   = aw_ok;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil.wdata;
          wstrb_d  = s_axil.wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_DECERR;
        end
      end
      W_RESP: begin
        if (s_axil.bready) begin
          w_state_d = W_COLLECT;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rresp_d   = ar_ok ? RESP_OKAY : RESP_DECERR;
        end
      end
      R_RESP: begin
        if (s_axil.rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_COLLECT;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  // Memory array with registered read; a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (rst) rdata_q <= '0;
    else if (ar_hs) rdata_q <= ar_ok ? mem_q[ar_idx] : '0;
  end
endmodule

// File: tb/tb_axil_mem_responder.sv
// Directed bench for axil_mem_responder: vector table plus multi-cycle corner sequences.
module tb_axil_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4)) bus ();

  axil_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .DEPTH(256)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axil (bus)
  );

  typedef struct {
    bit          is_write;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    @(negedge clk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("bvalid_n1", 32'(bus.bvalid), 32'd1);
    check("bresp", 32'(bus.bresp), 32'(exp_resp));
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_clr", 32'(bus.bvalid), 32'd0);
    $display("WRITE addr=%h data=%h strb=%h", addr, data, strb);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rvalid_n1", 32'(bus.rvalid), 32'd1);
    check("rdata", bus.rdata, exp_data);
    check("rresp", 32'(bus.rresp), 32'(exp_resp));
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("rvalid_clr", 32'(bus.rvalid), 32'd0);
    $display("READ  addr=%h data=%h resp=%h", addr, bus.rdata, bus.rresp);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
    vecs[1]  = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00};
    vecs[3]  = '{1'b1, 16'h0020, 32'h000000AB, 4'h1, 32'h0, 2'b00};
    vecs[4]  = '{1'b0, 16'h0020, 32'h0, 4'h0, 32'hFFFFFFAB, 2'b00};
    vecs[5]  = '{1'b1, 16'h0022, 32'h12345678, 4'h4, 32'h0, 2'b00};
    vecs[6]  = '{1'b0, 16'h0021, 32'h0, 4'h0, 32'hFF34FFAB, 2'b00};
    vecs[7]  = '{1'b1, 16'h0020, 32'h00000000, 4'h0, 32'h0, 2'b00};
    vecs[8]  = '{1'b0, 16'h0020, 32'h0, 4'h0, 32'hFF34FFAB, 2'b00};
    vecs[9]  = '{1'b1, 16'h03FC, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00};
    vecs[10] = '{1'b0, 16'h03FC, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00};

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state and readys held low during reset
    repeat (2) @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_bresp", 32'(bus.bresp), 32'd0);
    check("rst_rresp", 32'(bus.rresp), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", 32'(bus.awready), 32'd1);
    check("idle_wready", 32'(bus.wready), 32'd1);
    check("idle_arready", 32'(bus.arready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_write) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // W arrives two cycles before AW
    @(negedge clk);
    bus.wdata = 32'h11223344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("wfirst_wready", 32'(bus.wready), 32'd0);
    check("wfirst_bvalid", 32'(bus.bvalid), 32'd0);
    @(negedge clk);
    check("wfirst_awready", 32'(bus.awready), 32'd1);
    bus.awaddr = 16'h0004; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("wfirst_bvalid_n1", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    $display("WRITE W-before-AW addr=0004 data=11223344");
    do_read(16'h0004, 32'h11223344, 2'b00);

    // B backpressure with a second write pending on the bus
    do_write(16'h0030, 32'hA5A5A5A5, 4'hF, 2'b00);
    @(negedge clk);
    bus.awaddr = 16'h0030; bus.awvalid = 1'b1;
    bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp_bvalid", 32'(bus.bvalid), 32'd1);
      check("bp_awready", 32'(bus.awready), 32'd0);
      check("bp_wready", 32'(bus.wready), 32'd0);
      @(negedge clk);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    $display("WRITE backpressured addr=0030 data=0BADF00D");
    do_read(16'h0030, 32'h0BADF00D, 2'b00);
    do_write(16'h0030, 32'hA5A5A5A5, 4'hF, 2'b00);

    // R backpressure: rdata stable, no new AR accepted
    @(negedge clk);
    bus.araddr = 16'h0030; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.araddr = 16'h0010;
    for (int c = 0; c < 5; c++) begin
      check("rbp_rvalid", 32'(bus.rvalid), 32'd1);
      check("rbp_rdata", bus.rdata, 32'hA5A5A5A5);
      check("rbp_arready", 32'(bus.arready), 32'd0);
      @(negedge clk);
    end
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    $display("READ  backpressured addr=0030");

    // Same-edge read and write of word 3
    do_write(16'h000C, 32'h00000001, 4'hF, 2'b00);
    @(negedge clk);
    bus.awaddr = 16'h000C; bus.awvalid = 1'b1;
    bus.wdata = 32'h00000002; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 16'h000C; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("rbw_bvalid", 32'(bus.bvalid), 32'd1);
    check("rbw_rdata_old", bus.rdata, 32'h00000001);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    $display("RW    same-edge addr=000C");
    do_read(16'h000C, 32'h00000002, 2'b00);

`ifdef AXIL_MEM_DECERR_EN
    do_write(16'h0000, 32'h00000001, 4'hF, 2'b00);
    do_write(16'h0400, 32'h55AA55AA, 4'hF, 2'b11);
    do_read(16'h0400, 32'h00000000, 2'b11);
    do_read(16'h0000, 32'h00000001, 2'b00);
`else
    do_write(16'h0400, 32'h55AA55AA, 4'hF, 2'b00);
    do_read(16'h0000, 32'h55AA55AA, 2'b00);
`endif

    // Reset while bvalid is high drops the response
    @(negedge clk);
    bus.awaddr = 16'h0040; bus.awvalid = 1'b1;
    bus.wdata = 32'h00000007; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("rstmid_bvalid_pre", 32'(bus.bvalid), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_awready", 32'(bus.awready), 32'd0);
    check("rstmid_wready", 32'(bus.wready), 32'd0);
    check("rstmid_arready", 32'(bus.arready), 32'd0);
    @(negedge clk);
    check("rstmid_bvalid", 32'(bus.bvalid), 32'd0);
    rst = 1'b0;
    bus.bready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_b", 32'(bus.bvalid), 32'd0);
    end
    bus.bready = 1'b0;
    check("rstmid_awready_post", 32'(bus.awready), 32'd1);
    $display("RESET mid-write addr=0040");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
